// File: rtl/dmem_bus_ctrl_pkg.sv
// Shared definitions for the data-memory bus controller: FSM encoding and
// the default timeout / read-abort constants.
package dmem_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int          DEFAULT_TIMEOUT  = 255;
    localparam logic [31:0] READ_ABORT_VALUE = 32'h0;

endpackage

// File: rtl/dmem_bus_ctrl_if.sv
// Variable-latency memory bus between the controller (master) and memory (slave).
interface dmem_bus_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    // Handshake: bus_req rises with bus_we/bus_addr/bus_wdata valid and holds all
    // of them stable until memory answers with a one-cycle bus_ack (bus_rdata valid
    // in that same cycle); bus_req drops on the edge that samples bus_ack.
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );

endinterface

// File: rtl/dmem_bus_ctrl_timeout_ctr.sv
// Cycle counter for the BUSY wait; tc flags the last cycle before an abort.
module dmem_timeout_ctr
    import dmem_bus_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    assign tc = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Turns single-cycle core loads/stores into req/ack bus transactions,
// stalling the core until each one completes or times out.
module dmem_bus_ctrl
    import dmem_bus_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic [DATA_W-1:0] data_out,
    output logic              stall,
    output logic              align_err,
    output logic              bus_err,
    output state_t            dbgState,
    dmem_bus_ctrl_if.master   mbus
);

    state_t state;
    logic   access;
    logic   aligned;
    logic   timerTc;

    assign access   = mem_read | mem_write;
    assign aligned  = (data_addr[1:0] == 2'b00);
    assign dbgState = state;

    dmem_timeout_ctr #(.TIMEOUT(TIMEOUT)) uTimer (
        .clk (clk),
        .clr (reset || (state != ST_BUSY)),
        .en  (state == ST_BUSY),
        .tc  (timerTc)
    );

    // Stall goes up in the accepting IDLE cycle so the core never advances past it.
    always_comb begin
        stall = 1'b0;
        if (state == ST_BUSY) begin
            stall = 1'b1;
        end else if ((state == ST_IDLE) && access && aligned) begin
            stall = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            data_out       <= '0;
            mbus.bus_req   <= 1'b0;
            mbus.bus_we    <= 1'b0;
            mbus.bus_addr  <= '0;
            mbus.bus_wdata <= '0;
            align_err      <= 1'b0;
            bus_err        <= 1'b0;
        end else begin
            align_err <= 1'b0;
            bus_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        if (aligned) begin
                            mbus.bus_addr  <= data_addr;
                            mbus.bus_wdata <= data_in;
                            mbus.bus_we    <= mem_write;
                            mbus.bus_req   <= 1'b1;
                            state          <= ST_BUSY;
                        end else begin
                            align_err <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (mbus.bus_ack) begin
                        mbus.bus_req <= 1'b0;
                        if (!mbus.bus_we) begin
                            data_out <= mbus.bus_rdata;
                        end
                        state <= ST_DONE;
                    end else if (timerTc) begin
                        mbus.bus_req <= 1'b0;
                        bus_err      <= 1'b1;
                        if (!mbus.bus_we) begin
                            data_out <= DATA_W'(READ_ABORT_VALUE);
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Bench for dmem_bus_ctrl: directed and random loads/stores against a memory
// model, with bus responder and retirement monitor checking independently.
module tb_dmem_bus_ctrl;
    import dmem_bus_ctrl_pkg::*;

    localparam int TO = 4;
    localparam int EW = 42;  // {misaligned, bus_err, stall_cycles[7:0], data[31:0]}

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_addr = '0;
    logic [31:0] data_in = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] data_out;
    logic        stall;
    logic        align_err;
    logic        bus_err;
    state_t      dbgState;

    dmem_bus_ctrl_if #(.ADDR_W(32), .DATA_W(32)) mbus ();

    dmem_bus_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_addr (data_addr),
        .data_in   (data_in),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .data_out  (data_out),
        .stall     (stall),
        .align_err (align_err),
        .bus_err   (bus_err),
        .dbgState  (dbgState),
        .mbus      (mbus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          nTests = 0;
    int          nFail = 0;
    bit          checkEn = 1'b0;
    logic [EW-1:0] exp_q[$];
    int          delay_q[$];
    logic [64:0] busExp_q[$];
    logic [31:0] refMem[logic [31:0]];
    logic [31:0] slaveMem[logic [31:0]];
    logic [31:0] lastData = '0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver with reference model ----------------
    // op: 0 = read, 1 = write, 2 = read+write (acts as write)
    // dly: BUSY cycle on which memory acks (1..TO), 0 = never ack
    task automatic do_access(input int op, input logic [31:0] addr, input logic [31:0] wd,
                             input int dly, input int idle);
        logic        misal;
        logic        isWr;
        logic [31:0] expData;
        int          expStall;
        int          guard;
        misal   = (addr[1:0] != 2'b00);
        isWr    = (op != 0);
        expData = lastData;
        expStall = 0;
        if (!misal) begin
            expStall = (dly == 0) ? TO + 1 : dly + 1;
            delay_q.push_back(dly);
            busExp_q.push_back({isWr, addr, wd});
            if (isWr) begin
                if (dly != 0) refMem[addr] = wd;
            end else begin
                if (dly == 0) expData = 32'h0;
                else expData = refMem.exists(addr) ? refMem[addr] : 32'h0;
                lastData = expData;
            end
        end
        exp_q.push_back({misal, 1'(!misal && dly == 0), 8'(expStall), expData});
        data_addr = addr;
        data_in   = wd;
        mem_read  = (op != 1);
        mem_write = (op != 0);
        guard = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            guard++;
            if (guard > 50) begin
                nTests++;
                nFail++;
                $display("FAIL drive_timeout: stall still %0b after %0d cycles (t=%0t)", stall, guard, $time);
                break;
            end
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (idle) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- memory responder ----------------
    initial begin
        int          curDelay;
        int          cnt;
        int          reqCyc;
        bit          active;
        bit          lateAck;
        logic [64:0] cap;
        logic [64:0] be;
        curDelay = 0; cnt = 0; reqCyc = 0; active = 1'b0; lateAck = 1'b0; cap = '0;
        mbus.bus_ack   = 1'b0;
        mbus.bus_rdata = '0;
        forever begin
            @(negedge clk);
            mbus.bus_ack   = 1'b0;
            mbus.bus_rdata = $urandom;
            if (reset) begin
                active  = 1'b0;
                lateAck = 1'b0;
            end else if (mbus.bus_req) begin
                if (!active) begin
                    active = 1'b1;
                    cnt    = 0;
                    reqCyc = 0;
                    curDelay = (delay_q.size() != 0) ? delay_q.pop_front() : 0;
                    cap = {mbus.bus_we, mbus.bus_addr, mbus.bus_wdata};
                    if (busExp_q.size() != 0) begin
                        be = busExp_q.pop_front();
                        chk("bus_txn", 96'(cap), 96'(be));
                    end else begin
                        nTests++;
                        nFail++;
                        $display("FAIL bus_txn: unexpected request addr %0h (t=%0t)", mbus.bus_addr, $time);
                    end
                end else begin
                    chk("bus_stable", 96'({mbus.bus_we, mbus.bus_addr, mbus.bus_wdata}), 96'(cap));
                end
                cnt++;
                reqCyc++;
                if (curDelay != 0 && cnt == curDelay) begin
                    mbus.bus_ack = 1'b1;
                    if (mbus.bus_we) slaveMem[mbus.bus_addr] = mbus.bus_wdata;
                    else mbus.bus_rdata = slaveMem.exists(mbus.bus_addr) ? slaveMem[mbus.bus_addr] : 32'h0;
                end
            end else if (active) begin
                active = 1'b0;
                if (checkEn) chk("req_cycles", 96'(reqCyc), 96'((curDelay == 0) ? TO : curDelay));
                if (checkEn && curDelay == 0) lateAck = 1'b1;
            end else if (lateAck) begin
                mbus.bus_ack   = 1'b1;
                mbus.bus_rdata = 32'hDEAD_BEEF;
                lateAck = 1'b0;
            end
        end
    end

    // ---------------- retirement monitor ----------------
    initial begin
        logic [EW-1:0] e;
        int            stallCnt;
        logic          prevMis;
        logic [31:0]   curData;
        logic          acc;
        stallCnt = 0; prevMis = 1'b0; curData = '0;
        forever begin
            @(negedge clk);
            if (checkEn) begin
                acc = mem_read | mem_write;
                chk("align_err", 96'(align_err), 96'(prevMis));
                prevMis = 1'b0;
                if (stall) stallCnt++;
                if (acc && !stall) begin
                    if (exp_q.size() == 0) begin
                        nTests++;
                        nFail++;
                        $display("FAIL retire: no expected entry (t=%0t)", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data_out", 96'(data_out), 96'(e[31:0]));
                        chk("stall_cycles", 96'(stallCnt), 96'(e[39:32]));
                        chk("bus_err", 96'(bus_err), 96'(e[40]));
                        prevMis = e[41];
                        curData = e[31:0];
                    end
                    stallCnt = 0;
                end else begin
                    chk("bus_err_quiet", 96'(bus_err), 96'(0));
                    if (!acc) begin
                        chk("stall_idle", 96'(stall), 96'(0));
                        chk("req_idle", 96'(mbus.bus_req), 96'(0));
                        chk("data_hold", 96'(data_out), 96'(curData));
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int op;
        int dly;
        int idle;
        logic [31:0] addr;

        refMem[32'h10]   = 32'hCAFE_F00D;
        slaveMem[32'h10] = 32'hCAFE_F00D;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data_out", 96'(data_out), 96'(0));
        chk("rst_bus_req", 96'(mbus.bus_req), 96'(0));
        chk("rst_bus_we", 96'(mbus.bus_we), 96'(0));
        chk("rst_bus_addr", 96'(mbus.bus_addr), 96'(0));
        chk("rst_bus_wdata", 96'(mbus.bus_wdata), 96'(0));
        chk("rst_align_err", 96'(align_err), 96'(0));
        chk("rst_bus_err", 96'(bus_err), 96'(0));
        chk("rst_state", 96'(dbgState), 96'(ST_IDLE));
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkEn = 1'b1;
        @(posedge clk);
        #1;

        do_access(0, 32'h10, $urandom, 2, 0);              // load, ack on 2nd BUSY cycle
        do_access(1, 32'h20, 32'h1234_5678, 1, 0);         // store, immediate ack
        do_access(0, 32'h20, $urandom, 1, 1);              // load back, back-to-back
        do_access(0, 32'h13, $urandom, 1, 1);              // misaligned load
        do_access(1, 32'h22, $urandom, 1, 0);              // misaligned store
        do_access(0, 32'h30, $urandom, 0, 2);              // timeout read, late ack after
        do_access(2, 32'h40, 32'hA5A5_5A5A, 3, 0);         // read+write acts as write
        do_access(0, 32'h40, $urandom, TO, 0);             // ack on the timeout cycle
        do_access(1, 32'h44, $urandom, 0, 1);              // timeout write

        for (int i = 0; i < 60; i++) begin
            op   = $urandom_range(0, 2);
            addr = 32'h100 + 32'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 6) == 0) addr = addr + 32'($urandom_range(1, 3));
            dly  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TO);
            idle = (dly == 0) ? $urandom_range(1, 2) : $urandom_range(0, 2);
            do_access(op, addr, $urandom, dly, idle);
        end

        do_access(0, 32'h10, $urandom, 1, 0);              // data_out nonzero before reset
        chk("exp_q_drained", 96'(exp_q.size()), 96'(0));

        // reset during the second BUSY cycle of a load that never acks
        delay_q.push_back(0);
        busExp_q.push_back({1'b0, 32'h80, 32'h0});
        data_addr = 32'h80;
        data_in   = 32'h0;
        mem_read  = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkEn  = 1'b0;
        reset    = 1'b1;
        mem_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_bus_req", 96'(mbus.bus_req), 96'(0));
        chk("mid_rst_stall", 96'(stall), 96'(0));
        chk("mid_rst_data_out", 96'(data_out), 96'(0));
        chk("mid_rst_state", 96'(dbgState), 96'(ST_IDLE));
        chk("mid_rst_bus_err", 96'(bus_err), 96'(0));
        chk("mid_rst_align_err", 96'(align_err), 96'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_bus_err", 96'(bus_err), 96'(0));
            chk("post_rst_align_err", 96'(align_err), 96'(0));
            chk("post_rst_bus_req", 96'(mbus.bus_req), 96'(0));
            chk("post_rst_stall", 96'(stall), 96'(0));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
